// File: rtl/alu_issue.sv
// Execute-stage issue controller: decodes opcodes to ALU selects, drives the ALU, resolves branches.
// Optional macro ALU_ISSUE_TRAP_EN: opcodes 1101-1111 complete with out_illegal=1 and a zero result.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [15:0] in_rs1_data,
    input  logic [15:0] in_rs2_data,
    input  logic [15:0] in_imm,
    input  logic [15:0] in_pc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_branch_taken,
    output logic [15:0] out_branch_target,
    output logic        out_illegal
);
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;
    localparam int unsigned OW = 4;

    localparam logic [OW-1:0] OP_LW  = 4'h0;
    localparam logic [OW-1:0] OP_SW  = 4'h1;
    localparam logic [OW-1:0] OP_ADD = 4'h2;
    localparam logic [OW-1:0] OP_SUB = 4'h3;
    localparam logic [OW-1:0] OP_INV = 4'h4;
    localparam logic [OW-1:0] OP_SLL = 4'h5;
    localparam logic [OW-1:0] OP_SRL = 4'h6;
    localparam logic [OW-1:0] OP_AND = 4'h7;
    localparam logic [OW-1:0] OP_OR  = 4'h8;
    localparam logic [OW-1:0] OP_SLT = 4'h9;
    localparam logic [OW-1:0] OP_BEQ = 4'hA;
    localparam logic [OW-1:0] OP_BNE = 4'hB;
    localparam logic [OW-1:0] OP_JMP = 4'hC;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [OW-1:0] r_opcode;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_imm;
    logic          w_accept;
    logic [CW-1:0] w_ctrl;
    logic [DW-1:0] w_target;
    logic          w_is_branch;
    logic          w_taken;
    logic          w_trap;

    assign in_ready = ~rst & ((r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready));
    assign w_accept = in_valid & in_ready;

    // Branch target adder, independent of the ALU; wraps modulo 2^16
    assign w_target = r_pc + DW'(1) + r_imm;

`ifdef ALU_ISSUE_TRAP_EN
    assign w_trap = (r_opcode >= 4'hD);
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = in_valid ? S_EXEC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Opcode to ALU select; illegal opcodes fall through to add
    always_comb begin
        w_ctrl = 3'b000;
        case (in_opcode)
            OP_LW, OP_SW, OP_ADD, OP_JMP: w_ctrl = 3'b000;
            OP_SUB, OP_BEQ, OP_BNE:       w_ctrl = 3'b001;
            OP_INV:                       w_ctrl = 3'b010;
            OP_SLL:                       w_ctrl = 3'b011;
            OP_SRL:                       w_ctrl = 3'b100;
            OP_AND:                       w_ctrl = 3'b101;
            OP_OR:                        w_ctrl = 3'b110;
            OP_SLT:                       w_ctrl = 3'b111;
            default:                      w_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        case (r_opcode)
            OP_BEQ:  begin w_is_branch = 1'b1; w_taken = alu_zero;  end
            OP_BNE:  begin w_is_branch = 1'b1; w_taken = ~alu_zero; end
            OP_JMP:  begin w_is_branch = 1'b1; w_taken = 1'b1;      end
            default: begin w_is_branch = 1'b0; w_taken = 1'b0;      end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a             <= '0;
            alu_b             <= '0;
            alu_control       <= '0;
            r_opcode          <= '0;
            r_pc              <= '0;
            r_imm             <= '0;
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_zero          <= 1'b0;
            out_branch_taken  <= 1'b0;
            out_branch_target <= '0;
            out_illegal       <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a       <= in_rs1_data;
                alu_b       <= ((in_opcode == OP_LW) || (in_opcode == OP_SW)) ? in_imm : in_rs2_data;
                alu_control <= w_ctrl;
                r_opcode    <= in_opcode;
                r_pc        <= in_pc;
                r_imm       <= in_imm;
            end
            if (r_state == S_EXEC) begin
                if (w_trap)                   out_result <= '0;
                else if (r_opcode == OP_JMP)  out_result <= w_target;
                else                          out_result <= alu_result;
                out_zero          <= alu_zero;
                out_branch_taken  <= w_taken;
                out_branch_target <= w_is_branch ? w_target : '0;
                out_illegal       <= w_trap;
                out_valid         <= 1'b1;
            end else if ((r_state == S_HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue controller for the 16-bit RISC core. It accepts one decoded instruction at a time over a valid/ready handshake and maps the opcode to the ALU's 3-bit function select. It drives the ALU's `a`/`b` operands, samples the ALU's `result`/`zero`, and resolves branches. The outcome is presented to the memory/writeback stage on a registered valid/ready output.

## Interface
- No parameters; datapath fixed at 16 bits, ALU select at 3 bits.
- clk  in  1  rising-edge clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  controller can accept an instruction this cycle.
- in_opcode  in  4  instruction opcode.
- in_rs1_data  in  16  source operand 1.
- in_rs2_data  in  16  source operand 2.
- in_imm  in  16  immediate, already sign-extended by the decoder.
- in_pc  in  16  word address of the instruction.
- alu_a  out  16  ALU operand a.
- alu_b  out  16  ALU operand b.
- alu_control  out  3  ALU function select.
- alu_result  in  16  ALU result (combinational from alu_a, alu_b, alu_control).
- alu_zero  in  1  ALU result == 0.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_result  out  16  captured ALU result, or branch target for JMP.
- out_zero  out  1  captured alu_zero.
- out_branch_taken  out  1  redirect fetch.
- out_branch_target  out  16  redirect address.
- out_illegal  out  1  illegal opcode flag (see Configuration).

## Operation
- States:
  - IDLE: no transaction held.
  - EXEC: operands are driving the ALU.
  - HOLD: result is held for downstream.
- `in_ready` = (state==IDLE) | (state==HOLD & out_ready); forced 0 while rst=1.
- Accept (`in_valid & in_ready`):
  - Register `alu_a` = rs1.
  - Register `alu_b` = imm for LW/SW, rs2 otherwise.
  - Register the decoded `alu_control`, opcode, pc and imm.
  - Go to EXEC.
- Opcode decode to `alu_control`:
  - 0000 LW, 0001 SW → 000 (add)
  - 0010 ADD → 000
  - 0011 SUB → 001
  - 0100 INV → 010
  - 0101 SLL → 011
  - 0110 SRL → 100
  - 0111 AND → 101
  - 1000 OR → 110
  - 1001 SLT → 111
  - 1010 BEQ, 1011 BNE → 001
  - 1100 JMP → 000 (ALU result ignored)
  - 1101–1111 illegal
- EXEC, at its end edge:
  - `out_result` ← alu_result; for JMP, ← target.
  - `out_zero` ← alu_zero.
  - Compute branch outcome; `out_valid` ← 1; go to HOLD.
- Branch target = pc + 1 + imm, modulo 2^16 (wraps, no overflow flag); computed by an internal adder, never by the ALU.
- `out_branch_taken`:
  - BEQ: alu_zero.
  - BNE: ~alu_zero.
  - JMP: 1.
  - All other opcodes: 0, with `out_branch_target` = 0.
- HOLD with `out_ready`=1:
  - If `in_valid`=1, accept the new instruction, go to EXEC, `out_valid` ← 0.
  - Otherwise go to IDLE, `out_valid` ← 0.
- HOLD with `out_ready`=0: all outputs stable.
- Operands are passed to the ALU unmodified. Shift amounts ≥16 therefore yield 0. SLT is an unsigned compare.
- `alu_a`, `alu_b` and `alu_control` hold their last values outside EXEC.

## Timing
- Reset values: state IDLE, in_ready 0 (during rst), out_valid 0, out_result 0, out_zero 0, out_branch_taken 0, out_branch_target 0, out_illegal 0, alu_a 0, alu_b 0, alu_control 000.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N+1.
- Throughput: one instruction per 2 cycles with out_ready held high.
- rst=1 mid-EXEC or mid-HOLD discards the transaction; out_valid=0 after that edge. The controller does not accept in the rst cycle.
- `in_valid` asserted during EXEC is ignored, since in_ready=0; the source must hold.
- out_valid, once high, stays high until the out_ready handshake.

## Configuration
- `ALU_ISSUE_TRAP_EN` defined:
  - Opcodes 1101–1111 complete normally through EXEC/HOLD.
  - out_result=0, out_branch_taken=0, out_illegal=1 for that result only.
- `ALU_ISSUE_TRAP_EN` undefined:
  - Opcodes 1101–1111 decode as ADD with the rs2 operand.
  - out_illegal is tied 0.

## Test plan
- ADD: rs1=0x7FFF, rs2=0x0001, out_ready=1 → alu_control=000 in EXEC; out_result=0x8000 and out_zero=0 one cycle after accept; out_branch_taken=0.
- BEQ taken: rs1=rs2=0x1234, pc=0x0010, imm=0xFFFE → out_zero=1, out_branch_taken=1, out_branch_target=0x000F. BNE with the same operands → taken=0.
- Wrap: JMP with pc=0xFFFF, imm=0x0003 → out_branch_target=0x0003, out_branch_taken=1, out_result=0x0003.
- Backpressure: out_ready=0 for 5 cycles after a SUB of 5−5 → out_valid, out_result=0 and out_zero=1 stable; in_ready=0. Raise out_ready with in_valid=1 → drain and accept occur on the same edge.
- Reset mid-op: assert rst in EXEC of an SLL 1<<4 → out_valid=0 and all outputs 0 after the edge; no stale 0x0010 appears later.
- Illegal opcode 1111, rs1=2, rs2=3:
  - With `ALU_ISSUE_TRAP_EN` → out_illegal=1, out_result=0.
  - Without it → out_result=0x0005, out_illegal=0.
